mul_seq_unit: RTL and testbench
===============================

// Module: mul_seq_unit
// PURPOSE
//  Sequential shift-add unsigned multiplier: the DUT-side responder for the multiply checks our benches issue.
//  Accepts operands a,b on a valid/ready handshake, computes a*b over B_W cycles, returns an OUT_W result.
//  Returns a low-OUT_W-bit result plus an overflow flag, matching the bench reference function's truncating semantics.
//  Sits between a stimulus/checker initiator and a result consumer; one operation in flight.
// PARAMETERS
//  A_W    3  width of operand a (unsigned)
//  B_W    3  width of operand b (unsigned); also number of BUSY cycles
//  OUT_W  4  width of returned result; full product width is A_W+B_W internally
// PORTS
//  clk        in   1      clock, all state on rising edge
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      operands a,b valid
//  in_ready   out  1      block can accept operands
//  a          in   A_W    multiplicand
//  b          in   B_W    multiplier
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer accepts result
//  result     out  OUT_W  product (truncated, or saturated under MUL_SAT_EN)
//  ovf        out  1      1 when full product >= 2**OUT_W
// BEHAVIOUR
//  Reset (rst_n low, async): state=IDLE, in_ready=0 while asserted then 1, out_valid=0, result=0, ovf=0,
//   acc=0, cnt=0. Reset mid-BUSY/DONE abandons the operation; no result is emitted.
//  FSM IDLE -> BUSY -> DONE -> IDLE.
//   IDLE: in_ready=1. Edge with in_valid&&in_ready: latch a (zero-extended to A_W+B_W), b; acc=0; cnt=0; ->BUSY.
//   BUSY: in_ready=0. Each edge: if b_sh[0] acc+=a_sh; a_sh<<=1; b_sh>>=1; cnt++.
//    On the edge where cnt==B_W-1: load result/ovf from final acc; ->DONE.
//   DONE: out_valid=1; result, ovf stable until handshake. Edge with out_ready: out_valid=0; ->IDLE.
//  Latency: out_valid rises exactly B_W edges after the accepting edge; min issue interval B_W+2 cycles.
//  in_ready is 0 in BUSY and DONE; in_valid there is ignored (no queuing, no same-cycle turnaround).
//  out_ready outside DONE is ignored. out_valid never drops without out_ready.
//  Arithmetic: acc is A_W+B_W bits; it never overflows. ovf = |acc[A_W+B_W-1:OUT_W], or 0 if OUT_W>=A_W+B_W.
//  Operand 0 on either side: still takes B_W cycles, result=0, ovf=0.
// CONFIGURATION
//  MUL_SAT_EN defined: on ovf=1, result = all-ones (2**OUT_W-1); ovf still reported.
//  MUL_SAT_EN undefined: result = acc[OUT_W-1:0] (modulo 2**OUT_W truncation); ovf reported.
//  Timing and handshake are identical in both builds.
// STRUCTURE
//  Package mul_seq_pkg: typedef enum logic [1:0] {IDLE,BUSY,DONE} mul_state_t; function clog2-based
//   cnt width helper; localparam defaults A_W/B_W/OUT_W shared with benches.
//  One sub-module: mul_seq_fmt (combinational): full product -> {result, ovf}, holds MUL_SAT_EN logic.
//  Top keeps FSM, counter, shift registers and handshake.
// TESTING
//  1 a=7,b=2, out_ready=1 -> out_valid B_W=3 edges after accept, result=14, ovf=0 (both builds).
//  2 a=7,b=7 -> ovf=1; result=1 without MUL_SAT_EN, result=15 with MUL_SAT_EN.
//  3 a=0,b=5 and a=5,b=0 -> result=0, ovf=0, latency still 3 cycles.
//  4 a=3,b=3, out_ready held 0 for 4 cycles -> out_valid stays 1, result=9 stable, in_ready=0; then accepted.
//  5 rst_n pulsed low during BUSY of a=6,b=5 -> outputs reset immediately, no out_valid; next op a=2,b=3 -> 6.
//  6 back-to-back in_valid held high with 8 operand pairs -> each accepted only in IDLE, all results match
//    bench mul() function; in_valid during BUSY/DONE never changes latched operands.

Source files
------------

// File: rtl/mul_seq_pkg.sv
// Shared types, default widths and helpers for the sequential shift-add multiplier.
package mul_seq_pkg;

  localparam int DEF_A_W   = 3;
  localparam int DEF_B_W   = 3;
  localparam int DEF_OUT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mul_state_t;

  // Bits needed to count 0 .. n-1, never less than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mul_seq_unit_if.sv
// Operand/result handshake bundle between an initiator (master) and mul_seq_unit (slave).
interface mul_seq_unit_if
  import mul_seq_pkg::*;
#(
  parameter int A_W   = DEF_A_W,
  parameter int B_W   = DEF_B_W,
  parameter int OUT_W = DEF_OUT_W
);

  logic             in_valid;
  logic             in_ready;
  logic [A_W-1:0]   a;
  logic [B_W-1:0]   b;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] result;
  logic             ovf;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, result, ovf
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, result, ovf
  );

endinterface

// File: rtl/mul_seq_fmt.sv
// Combinational formatter: full product -> {result, ovf}.
// With MUL_SAT_EN defined an overflowing product saturates to all-ones instead of truncating.
module mul_seq_fmt #(
  parameter int P_W   = 6,
  parameter int OUT_W = 4
) (
  input  logic [P_W-1:0]   prod,
  output logic [OUT_W-1:0] result,
  output logic             ovf
);

  generate
    if (OUT_W >= P_W) begin : g_wide
      assign result = OUT_W'(prod);
      assign ovf    = 1'b0;
    end else begin : g_narrow
      logic ovf_s;
      assign ovf_s = |prod[P_W-1:OUT_W];
`ifdef MUL_SAT_EN
      assign result = ovf_s ? {OUT_W{1'b1}} : prod[OUT_W-1:0];
`else
      assign result = prod[OUT_W-1:0];
`endif
      assign ovf = ovf_s;
    end
  endgenerate

endmodule

// File: rtl/mul_seq_unit.sv
// Sequential shift-add unsigned multiplier, one operation in flight, B_W busy cycles.
// Optional saturation of the returned result is selected with MUL_SAT_EN (see mul_seq_fmt).
module mul_seq_unit
  import mul_seq_pkg::*;
#(
  parameter int A_W   = DEF_A_W,
  parameter int B_W   = DEF_B_W,
  parameter int OUT_W = DEF_OUT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  mul_seq_unit_if.slave bus
);

  localparam int P_W   = A_W + B_W;
  localparam int CNT_W = cnt_width(B_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(B_W - 1);

  mul_state_t       state_r;
  mul_state_t       state_nxt_s;
  logic [P_W-1:0]   a_sh_r;
  logic [B_W-1:0]   b_sh_r;
  logic [P_W-1:0]   acc_r;
  logic [P_W-1:0]   acc_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic             in_ready_r;
  logic             in_ready_nxt_s;
  logic             out_valid_r;
  logic             out_valid_nxt_s;
  logic [OUT_W-1:0] result_r;
  logic             ovf_r;
  logic [OUT_W-1:0] fmt_result_s;
  logic             fmt_ovf_s;
  logic             accept_s;
  logic             last_s;

  assign accept_s = (state_r == IDLE) && in_ready_r && bus.in_valid;
  assign last_s   = (state_r == BUSY) && (cnt_r == CNT_LAST);

  // Partial-product accumulation for the current multiplier bit.
  always_comb begin
    acc_nxt_s = acc_r;
    if (b_sh_r[0]) begin
      acc_nxt_s = acc_r + a_sh_r;
    end else begin
      acc_nxt_s = acc_r;
    end
  end

  // The formatter sees the final accumulator value on the last busy edge.
  mul_seq_fmt #(
    .P_W  (P_W),
    .OUT_W(OUT_W)
  ) u_fmt (
    .prod  (acc_nxt_s),
    .result(fmt_result_s),
    .ovf   (fmt_ovf_s)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_nxt_s = BUSY;
        else          state_nxt_s = IDLE;
      end
      BUSY: begin
        if (last_s) state_nxt_s = DONE;
        else        state_nxt_s = BUSY;
      end
      DONE: begin
        if (bus.out_ready) state_nxt_s = IDLE;
        else               state_nxt_s = DONE;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM outputs, decoded from the upcoming state so the handshake flags are registered.
  always_comb begin
    in_ready_nxt_s  = 1'b0;
    out_valid_nxt_s = 1'b0;
    case (state_nxt_s)
      IDLE:    in_ready_nxt_s  = 1'b1;
      DONE:    out_valid_nxt_s = 1'b1;
      default: begin
        in_ready_nxt_s  = 1'b0;
        out_valid_nxt_s = 1'b0;
      end
    endcase
  end

  // Operand shift registers, accumulator and step counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_r <= {P_W{1'b0}};
      b_sh_r <= {B_W{1'b0}};
      acc_r  <= {P_W{1'b0}};
      cnt_r  <= {CNT_W{1'b0}};
    end else if (accept_s) begin
      a_sh_r <= {{B_W{1'b0}}, bus.a};
      b_sh_r <= bus.b;
      acc_r  <= {P_W{1'b0}};
      cnt_r  <= {CNT_W{1'b0}};
    end else if (state_r == BUSY) begin
      acc_r  <= acc_nxt_s;
      a_sh_r <= a_sh_r << 1'b1;
      b_sh_r <= b_sh_r >> 1'b1;
      cnt_r  <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      acc_r  <= acc_r;
      a_sh_r <= a_sh_r;
      b_sh_r <= b_sh_r;
      cnt_r  <= cnt_r;
    end
  end

  // Registered handshake flags and result, held stable through DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      result_r    <= {OUT_W{1'b0}};
      ovf_r       <= 1'b0;
    end else begin
      in_ready_r  <= in_ready_nxt_s;
      out_valid_r <= out_valid_nxt_s;
      if (last_s) begin
        result_r <= fmt_result_s;
        ovf_r    <= fmt_ovf_s;
      end else begin
        result_r <= result_r;
        ovf_r    <= ovf_r;
      end
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.result    = result_r;
  assign bus.ovf       = ovf_r;

endmodule

// File: tb/tb_mul_seq_unit.sv
// Self-checking bench for mul_seq_unit: cycle-level behavioural model plus directed literal checks.
// Build with MUL_SAT_EN defined to check the saturating variant.
module tb_mul_seq_unit;
  import mul_seq_pkg::*;

  localparam int A_W   = DEF_A_W;
  localparam int B_W   = DEF_B_W;
  localparam int OUT_W = DEF_OUT_W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mul_seq_unit_if #(.A_W(A_W), .B_W(B_W), .OUT_W(OUT_W)) bus ();

  mul_seq_unit #(.A_W(A_W), .B_W(B_W), .OUT_W(OUT_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  // Reference: {ovf, result} from the plain integer product.
  function automatic logic [OUT_W:0] mul(input int unsigned x, input int unsigned y);
    int unsigned full;
    int unsigned r;
    logic ov;
    full = x * y;
    ov   = (full >= (32'd1 << OUT_W));
    r    = full % (32'd1 << OUT_W);
`ifdef MUL_SAT_EN
    if (ov) r = (32'd1 << OUT_W) - 32'd1;
`endif
    return {ov, OUT_W'(r)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Cycle model: phase 0 idle, 1 busy, 2 done; evaluated on the falling edge.
  int               m_phase = 0;
  int               m_rem = 0;
  int               m_done_cnt = 0;
  int               d_done_cnt = 0;
  logic             m_rdy = 1'b0;
  logic             m_vld = 1'b0;
  logic             m_ovf = 1'b0;
  logic [OUT_W-1:0] m_res = '0;
  logic [OUT_W:0]   m_pend = '0;

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      m_phase = 0;
      m_rdy   = 1'b0;
      m_vld   = 1'b0;
      m_res   = '0;
      m_ovf   = 1'b0;
    end
    chk("in_ready", bus.in_ready, m_rdy);
    chk("out_valid", bus.out_valid, m_vld);
    if (m_vld || !rst_n) begin
      chk("result", bus.result, m_res);
      chk("ovf", bus.ovf, m_ovf);
    end
    if (rst_n) begin
      if (bus.out_valid && bus.out_ready) d_done_cnt++;
      case (m_phase)
        0: begin
          if (m_rdy && bus.in_valid) begin
            m_pend  = mul(bus.a, bus.b);
            m_rdy   = 1'b0;
            m_rem   = B_W;
            m_phase = 1;
          end else begin
            m_rdy = 1'b1;
          end
        end
        1: begin
          m_rem--;
          if (m_rem == 0) begin
            m_phase = 2;
            m_vld   = 1'b1;
            m_res   = m_pend[OUT_W-1:0];
            m_ovf   = m_pend[OUT_W];
          end
        end
        default: begin
          if (bus.out_ready) begin
            m_vld   = 1'b0;
            m_rdy   = 1'b1;
            m_phase = 0;
            m_done_cnt++;
          end
        end
      endcase
    end
  end

  // One directed operation; starts and ends one time step after a rising edge.
  task automatic op(input logic [A_W-1:0] x, input logic [B_W-1:0] y, input int hold,
                    input logic [OUT_W-1:0] er, input logic eo, input string nm);
    int n;
    int lat;
    logic [OUT_W-1:0] held;
    bus.a         = x;
    bus.b         = y;
    bus.in_valid  = 1'b1;
    bus.out_ready = (hold == 0);
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({nm, " accept"}, n < 20, 1);
    step();
    bus.in_valid = 1'b0;
    lat = 0;
    @(negedge clk);
    while (!bus.out_valid && lat < 20) begin
      lat++;
      @(negedge clk);
    end
    chk({nm, " latency"}, lat, B_W);
    chk({nm, " result"}, bus.result, er);
    chk({nm, " ovf"}, bus.ovf, eo);
    if (hold > 0) begin
      held = bus.result;
      repeat (hold) begin
        @(negedge clk);
        chk({nm, " held valid"}, bus.out_valid, 1);
        chk({nm, " held result"}, bus.result, held);
        chk({nm, " held in_ready"}, bus.in_ready, 0);
      end
      step();
      bus.out_ready = 1'b1;
    end
    step();
    @(negedge clk);
    chk({nm, " released"}, bus.out_valid, 0);
    step();
  endtask

  initial begin
    int n;
    int base_m;
    int base_d;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b1;

    // Pin the reference function with hand-computed values.
    chk("model 7*2", mul(7, 2), 32'd14);
`ifdef MUL_SAT_EN
    chk("model 7*7", mul(7, 7), 32'd31);
`else
    chk("model 7*7", mul(7, 7), 32'd17);
`endif
    chk("model 0*5", mul(0, 5), 32'd0);
    chk("model 3*3", mul(3, 3), 32'd9);

    repeat (3) step();
    chk("reset out_valid", bus.out_valid, 0);
    chk("reset in_ready", bus.in_ready, 0);
    rst_n = 1'b1;
    repeat (2) step();

    op(3'd7, 3'd2, 0, 4'd14, 1'b0, "t1 7*2");
`ifdef MUL_SAT_EN
    op(3'd7, 3'd7, 0, 4'd15, 1'b1, "t2 7*7");
`else
    op(3'd7, 3'd7, 0, 4'd1, 1'b1, "t2 7*7");
`endif
    op(3'd0, 3'd5, 0, 4'd0, 1'b0, "t3 0*5");
    op(3'd5, 3'd0, 0, 4'd0, 1'b0, "t3 5*0");
    op(3'd3, 3'd3, 4, 4'd9, 1'b0, "t4 3*3 stall");

    // Reset in the middle of a busy operation.
    bus.a        = 3'd6;
    bus.b        = 3'd5;
    bus.in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t5 accept", n < 20, 1);
    step();
    bus.in_valid = 1'b0;
    step();
    rst_n = 1'b0;
    @(negedge clk);
    chk("t5 rst out_valid", bus.out_valid, 0);
    chk("t5 rst result", bus.result, 0);
    step();
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("t5 no result", bus.out_valid, 0);
    end
    step();
    op(3'd2, 3'd3, 0, 4'd6, 1'b0, "t5 2*3");

    // in_valid held high, operands scrambled every cycle, consumer stalls at random.
    base_m = m_done_cnt;
    base_d = d_done_cnt;
    bus.in_valid = 1'b1;
    n = 0;
    while (m_done_cnt < base_m + 8 && n < 300) begin
      bus.a         = A_W'($urandom);
      bus.b         = B_W'($urandom);
      bus.out_ready = 1'($urandom_range(0, 1));
      step();
      n++;
    end
    chk("t6 dut completions", d_done_cnt - base_d, 8);

    // Fully random traffic.
    repeat (400) begin
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.a         = A_W'($urandom);
      bus.b         = B_W'($urandom);
      bus.out_ready = 1'($urandom_range(0, 1));
      step();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (10) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
